// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, two-entry skid buffer, sync flush.
// Define PIPE_BUBBLE_ZERO_EN to force out_data to zero whenever the stage holds no valid entry.
module pipe_stage_skid #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             fire;

  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (fire) begin
          state_d = EMPTY;
`ifdef PIPE_BUBBLE_ZERO_EN
          main_d  = '0;
`endif
        end
      end
      FULL: begin
        if (fire) begin
          state_d = ONE;
          main_d  = skid_q;
`ifdef PIPE_BUBBLE_ZERO_EN
          skid_d  = '0;
`endif
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every transition; an out-fire this cycle has still completed downstream.
    if (flush) begin
      state_d = EMPTY;
`ifdef PIPE_BUBBLE_ZERO_EN
      main_d  = '0;
      skid_d  = '0;
`endif
    end
  end

  // Handshake flags are derived from next state so both ports come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed handshake, back-pressure, flush, reset and random drain.
module tb_pipe_stage_skid;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  int nfire  = 0;
  logic [W-1:0] exp_q[$];
  bit rand_or = 1'b0;

  pipe_stage_skid #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at the falling edge the upcoming rising-edge transfers are fully determined.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      if (out_valid && out_ready) begin
        nfire++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Presents d until accepted; returns 1 ns after the accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] d);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 32'(d), 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [W-1:0] v;
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single payload latency
    out_ready = 1'b1;
    send(16'h00A5);
    in_valid = 1'b0;
    chk("a5_out_valid", 32'(out_valid), 32'd1);
    chk("a5_out_data", 32'(out_data), 32'h00A5);
    chk("a5_occupancy", 32'(occupancy), 32'd1);
    chk("a5_in_ready", 32'(in_ready), 32'd1);
    step();

    // Back-to-back stream at full throughput
    base = nfire;
    for (int i = 1; i <= 8; i++) send(16'(i));
    in_valid = 1'b0;
    step();
    chk("stream_fires", 32'(nfire - base), 32'd8);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    send(16'h0011);
    send(16'h0022);
    in_valid = 1'b0;
    chk("full_occupancy", 32'(occupancy), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_data", 32'(out_data), 32'h0011);
    out_ready = 1'b1;
    step();
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    chk("drain1_out_data", 32'(out_data), 32'h0022);
    step();
    chk("drain2_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_BUBBLE_ZERO_EN
    chk("drain2_out_data", 32'(out_data), 32'h0000);
`else
    chk("drain2_out_data", 32'(out_data), 32'h0022);
`endif

    // Flush from FULL with an offered payload
    out_ready = 1'b0;
    send(16'h0033);
    send(16'h0044);
    in_data = 16'h0055;
    flush   = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flushF_out_valid", 32'(out_valid), 32'd0);
    chk("flushF_occupancy", 32'(occupancy), 32'd0);
    chk("flushF_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_BUBBLE_ZERO_EN
    chk("flushF_out_data", 32'(out_data), 32'h0000);
`else
    chk("flushF_out_data", 32'(out_data), 32'h0033);
`endif

    // Flush from ONE with simultaneous accept and out-fire
    send(16'h0066);
    in_data   = 16'h0077;
    out_ready = 1'b1;
    flush     = 1'b1;
    base      = nfire;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_fire_counted", 32'(nfire - base), 32'd1);
    chk("flush1_out_valid", 32'(out_valid), 32'd0);
    chk("flush1_occupancy", 32'(occupancy), 32'd0);
    step();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(16'h0088);
    send(16'h0099);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Random back-pressure over 1000 payloads
    rand_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
      send(v);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid  = 1'b0;
    rand_or   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    chk("random_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
